fft_frame_pingpong: RTL and testbench

FFT_FRAME_PINGPONG -- requirements
Module: fft_frame_pingpong

---
 rtl/fft_frame_pingpong.sv | 139 +++++++++++++
 tb/tb_fft_frame_pingpong.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_pingpong.sv
// Ping-pong frame buffer: a writer fills DEPTH-sample frames into two banks,
// a consumer reads the oldest full bank and releases it with frame_done.
//
// state | meaning
// FILL  | writer bank is free; each accepted sample goes to wr_bank at wr_ptr
// STALL | both banks full; incoming samples are dropped and flag overrun
module fft_frame_pingpong #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_ready,
  output logic              rd_bank,
  input  logic              frame_done,
  output logic              overrun,
  input  logic              clear_overrun,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {FILL, STALL} wr_state_e;

  wr_state_e         state, state_next;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_ptr;
  logic [1:0]        bank_full, bank_full_next;
  logic              release_bank;
  logic              last_slot;
  logic              other_free;
  logic              ram_we;
  logic              set_full;
  logic              wr_toggle;
  logic              drop;

  // Both banks share one array; the bank index is the top address bit.
  logic [DATA_W-1:0] mem [0:2*DEPTH-1];

  assign frame_ready  = bank_full[rd_bank];
  assign release_bank = frame_done & bank_full[rd_bank];
  assign last_slot    = &wr_ptr;
  // The other bank counts as free if the consumer hands it back this very cycle.
  assign other_free   = ~bank_full[~wr_bank] | (release_bank & (rd_bank != wr_bank));

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL:    if (sample_valid && last_slot && !other_free) state_next = STALL;
        STALL:   if (release_bank) state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    set_full  = 1'b0;
    wr_toggle = 1'b0;
    drop      = 1'b0;
    if (!reset && !flush) begin
      case (state)
        FILL: begin
          ram_we    = sample_valid;
          set_full  = sample_valid & last_slot;
          wr_toggle = sample_valid & last_slot & other_free;
        end
        STALL: begin
          drop      = sample_valid;
          wr_toggle = release_bank;
        end
        default: begin
          ram_we = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bank_full_next = bank_full;
    if (set_full)     bank_full_next[wr_bank] = 1'b1;
    if (release_bank) bank_full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      overrun   <= 1'b0;
    end else begin
      if (ram_we)
        wr_ptr <= wr_ptr + 1'b1;
      else if (state == STALL && release_bank)
        wr_ptr <= '0;
      if (wr_toggle)    wr_bank <= ~wr_bank;
      if (release_bank) rd_bank <= ~rd_bank;
      bank_full <= bank_full_next;
      if (set_full)     frame_cnt <= frame_cnt + 1'b1;
      if (drop)
        overrun <= 1'b1;
      else if (clear_overrun)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[{wr_bank, wr_ptr}] <= sample_in;
  end

  // Read-before-write: a same-address write returns the previous contents.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: tb/tb_fft_frame_pingpong.sv
// Self-checking bench: small-depth instance checked every cycle against a
// frame-level model, plus a default-parameter instance with directed checks.
module tb_fft_frame_pingpong;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        flush;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        frame_ready;
  logic        rd_bank;
  logic        frame_done;
  logic        overrun;
  logic        clear_overrun;
  logic [15:0] frame_cnt;

  logic [31:0] b_sample_in;
  logic        b_sample_valid;
  logic        b_flush;
  logic [8:0]  b_rd_addr;
  logic [31:0] b_rd_data;
  logic        b_frame_ready;
  logic        b_rd_bank;
  logic        b_frame_done;
  logic        b_overrun;
  logic        b_clear_overrun;
  logic [15:0] b_frame_cnt;

  fft_frame_pingpong #(.DATA_W(32), .ADDR_W(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .flush(flush), .rd_addr(rd_addr), .rd_data(rd_data), .frame_ready(frame_ready),
    .rd_bank(rd_bank), .frame_done(frame_done), .overrun(overrun),
    .clear_overrun(clear_overrun), .frame_cnt(frame_cnt)
  );

  fft_frame_pingpong dut_b (
    .clk(clk), .reset(reset), .sample_in(b_sample_in), .sample_valid(b_sample_valid),
    .flush(b_flush), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .frame_ready(b_frame_ready),
    .rd_bank(b_rd_bank), .frame_done(b_frame_done), .overrun(b_overrun),
    .clear_overrun(b_clear_overrun), .frame_cnt(b_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Frame-level model: pending full frames, releases and completions since
  // the last flush; consumer bank = releases mod 2, writer bank = completions mod 2.
  logic [31:0] mmem   [2][DEPTH];
  bit          mknown [2][DEPTH];
  int          m_full, m_rel, m_done, m_ptr, m_cnt;
  bit          m_ovr;
  logic [31:0] m_rd_exp;
  bit          m_rd_known;
  logic [31:0] bdata [512];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int rb, wb;
    bit rel, dropped;
    rb = m_rel % 2;
    if (reset) begin
      m_rd_exp = 32'd0; m_rd_known = 1'b1;
      m_full = 0; m_rel = 0; m_done = 0; m_ptr = 0; m_cnt = 0; m_ovr = 1'b0;
    end else begin
      m_rd_exp   = mmem[rb][rd_addr];
      m_rd_known = mknown[rb][rd_addr];
      if (flush) begin
        m_full = 0; m_rel = 0; m_done = 0; m_ptr = 0; m_ovr = 1'b0;
      end else begin
        rel     = frame_done && (m_full > 0);
        dropped = 1'b0;
        if (sample_valid) begin
          if (m_full == 2) dropped = 1'b1;
          else begin
            wb = m_done % 2;
            mmem[wb][m_ptr]   = sample_in;
            mknown[wb][m_ptr] = 1'b1;
            m_ptr++;
            if (m_ptr == DEPTH) begin
              m_ptr = 0; m_done++; m_full++;
              m_cnt = (m_cnt + 1) % 65536;
            end
          end
        end
        if (dropped) m_ovr = 1'b1;
        else if (clear_overrun) m_ovr = 1'b0;
        if (rel) begin m_full--; m_rel++; end
      end
    end
  endtask

  task automatic compare_all();
    chk("frame_ready", {63'd0, frame_ready}, {63'd0, (m_full > 0)});
    chk("rd_bank", {63'd0, rd_bank}, 64'(m_rel % 2));
    chk("overrun", {63'd0, overrun}, {63'd0, m_ovr});
    chk("frame_cnt", {48'd0, frame_cnt}, 64'(m_cnt));
    if (m_rd_known) chk("rd_data", {32'd0, rd_data}, {32'd0, m_rd_exp});
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    sample_valid = 1'b0; frame_done = 1'b0; flush = 1'b0; clear_overrun = 1'b0;
    b_sample_valid = 1'b0; b_frame_done = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] d);
    sample_valid = 1'b1; sample_in = d;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) begin
        mmem[b][a] = 32'd0; mknown[b][a] = 1'b0;
      end
    m_full = 0; m_rel = 0; m_done = 0; m_ptr = 0; m_cnt = 0; m_ovr = 1'b0;
    m_rd_exp = 32'd0; m_rd_known = 1'b0;
    sample_in = 32'd0; rd_addr = 3'd0; b_sample_in = 32'd0; b_rd_addr = 9'd0;
    b_flush = 1'b0; b_clear_overrun = 1'b0;
    idle();
    reset = 1'b1;
    #2;
    step(); step();
    chk("reset frame_ready", {63'd0, frame_ready}, 64'd0);
    chk("reset frame_cnt", {48'd0, frame_cnt}, 64'd0);
    chk("reset overrun", {63'd0, overrun}, 64'd0);
    chk("reset rd_data", {32'd0, rd_data}, 64'd0);
    reset = 1'b0;

    // Default-parameter instance: ignored frame_done, one full 512-sample frame.
    b_frame_done = 1'b1; step(); b_frame_done = 1'b0;
    chk("b ignored done ready", {63'd0, b_frame_ready}, 64'd0);
    chk("b ignored done bank", {63'd0, b_rd_bank}, 64'd0);
    for (int k = 0; k < 512; k++) begin
      bdata[k] = $urandom;
      b_sample_in = bdata[k]; b_sample_valid = 1'b1;
      step();
    end
    b_sample_valid = 1'b0;
    chk("b frame_ready", {63'd0, b_frame_ready}, 64'd1);
    chk("b frame_cnt", {48'd0, b_frame_cnt}, 64'd1);
    chk("b overrun", {63'd0, b_overrun}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      b_rd_addr = (k == 3) ? 9'd511 : 9'($urandom_range(0, 511));
      step();
      chk("b rd_data", {32'd0, b_rd_data}, {32'd0, bdata[b_rd_addr]});
    end
    b_frame_done = 1'b1; step(); b_frame_done = 1'b0;
    chk("b release bank", {63'd0, b_rd_bank}, 64'd1);
    b_frame_done = 1'b1; step(); b_frame_done = 1'b0;
    chk("b stray done bank", {63'd0, b_rd_bank}, 64'd1);
    chk("b stray done cnt", {48'd0, b_frame_cnt}, 64'd1);

    // First frame 0..7 into bank 0.
    for (int k = 0; k < 8; k++) strobe(32'(k));
    chk("f1 ready", {63'd0, frame_ready}, 64'd1);
    chk("f1 rd_bank", {63'd0, rd_bank}, 64'd0);
    chk("f1 cnt", {48'd0, frame_cnt}, 64'd1);
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k); step();
      chk("f1 readback", {32'd0, rd_data}, 64'(k));
    end

    // Second frame fills bank 1, then the 17th sample is dropped.
    for (int k = 0; k < 8; k++) strobe(32'(100 + k));
    chk("stall cnt", {48'd0, frame_cnt}, 64'd2);
    chk("stall no overrun", {63'd0, overrun}, 64'd0);
    strobe(32'd999);
    chk("17th overrun", {63'd0, overrun}, 64'd1);
    rd_addr = 3'd3; step();
    chk("bank0 intact", {32'd0, rd_data}, 64'd3);

    // Release during stall with a simultaneous (dropped) sample.
    frame_done = 1'b1; sample_valid = 1'b1; sample_in = 32'hDEAD;
    step(); idle();
    chk("stall release bank", {63'd0, rd_bank}, 64'd1);
    chk("stall release ready", {63'd0, frame_ready}, 64'd1);
    strobe(32'h55);
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
    chk("clear overrun", {63'd0, overrun}, 64'd0);
    frame_done = 1'b1; step(); frame_done = 1'b0;
    chk("release bank1", {63'd0, rd_bank}, 64'd0);
    rd_addr = 3'd0; step();
    chk("post-stall addr0", {32'd0, rd_data}, 64'h55);

    // Flush mid-frame, then a clean frame in bank 0.
    flush = 1'b1; step(); flush = 1'b0;
    for (int k = 0; k < 5; k++) strobe(32'(200 + k));
    flush = 1'b1; sample_valid = 1'b1; sample_in = 32'hBAD;
    step(); idle();
    chk("flush ready", {63'd0, frame_ready}, 64'd0);
    chk("flush overrun", {63'd0, overrun}, 64'd0);
    chk("flush cnt kept", {48'd0, frame_cnt}, 64'd2);
    for (int k = 0; k < 8; k++) strobe(32'(300 + k));
    chk("post-flush ready", {63'd0, frame_ready}, 64'd1);
    chk("post-flush cnt", {48'd0, frame_cnt}, 64'd3);
    rd_addr = 3'd0; step();
    chk("post-flush addr0", {32'd0, rd_data}, 64'd300);

    // Last write of bank 1 coincides with release of bank 0: no stall.
    for (int k = 0; k < 7; k++) strobe(32'(400 + k));
    frame_done = 1'b1; strobe(32'd407); frame_done = 1'b0;
    chk("race overrun", {63'd0, overrun}, 64'd0);
    chk("race rd_bank", {63'd0, rd_bank}, 64'd1);
    chk("race cnt", {48'd0, frame_cnt}, 64'd4);
    strobe(32'd500);
    chk("race accepted", {63'd0, overrun}, 64'd0);
    rd_addr = 3'd7; step();
    chk("race bank1 last", {32'd0, rd_data}, 64'd407);
    frame_done = 1'b1; step(); frame_done = 1'b0;
    rd_addr = 3'd0; step();
    chk("race bank0 addr0", {32'd0, rd_data}, 64'd500);

    // Randomized traffic, model-checked every cycle.
    for (int c = 0; c < 1500; c++) begin
      sample_valid  = ($urandom_range(0, 99) < 60);
      sample_in     = $urandom;
      frame_done    = ($urandom_range(0, 99) < 12);
      flush         = ($urandom_range(0, 99) < 2);
      clear_overrun = ($urandom_range(0, 99) < 5);
      reset         = ($urandom_range(0, 199) == 0);
      rd_addr       = 3'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
